// File: rtl/voice_bank_scheduler.sv
// Round-robin voice slot scheduler feeding the pipelined sine generator.
// Allocates/frees voice slots from note-on/note-off commands; emits one slot per enabled cycle.
module voice_bank_scheduler #(
  parameter int NBANKS = 10,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              panic,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_on,
  input  logic [6:0]        cmd_midi,
  input  logic [23:0]       cmd_incr,
  output logic [23:0]       o_phase,
  output logic [6:0]        o_midi,
  output logic              o_valid,
  output logic [SLOT_W-1:0] o_slot,
  output logic [NBANKS-1:0] o_active,
  output logic              o_drop
);

  logic [NBANKS-1:0] active;
  logic [6:0]        midi  [NBANKS];
  logic [23:0]       phase [NBANKS];
  logic [23:0]       incr  [NBANKS];
  logic [SLOT_W-1:0] slot;

  logic              hit;
  logic [SLOT_W-1:0] hit_idx;
  logic              free_any;
  logic [SLOT_W-1:0] free_idx;
  logic              cmd_fire;

  function automatic logic [23:0] phase_step(input logic [23:0] acc, input logic [23:0] step);
    return acc + step;
  endfunction

  assign cmd_ready = clk_en & ~panic & rst;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign o_active  = active;

  // Descending scan so the lowest matching / free index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int k = NBANKS - 1; k >= 0; k--) begin
      if (active[k] && (midi[k] == cmd_midi)) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(k);
      end
      if (!active[k]) begin
        free_any = 1'b1;
        free_idx = SLOT_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= '0;
      slot    <= '0;
      o_phase <= '0;
      o_midi  <= '0;
      o_valid <= 1'b0;
      o_slot  <= '0;
      o_drop  <= 1'b0;
      for (int k = 0; k < NBANKS; k++) begin
        midi[k]  <= '0;
        phase[k] <= '0;
        incr[k]  <= '0;
      end
    end else if (!clk_en) begin
      o_drop <= 1'b0;
    end else begin
      // Emission stage: outputs always reflect the state before this edge's writes.
      o_phase <= phase[slot];
      o_midi  <= midi[slot];
      o_valid <= active[slot];
      o_slot  <= slot;
      o_drop  <= 1'b0;

      if (active[slot] && !panic)
        phase[slot] <= phase_step(phase[slot], incr[slot]);

      if (panic)
        active <= '0;

      // Command writes come last so they override the accumulator update on a collision.
      if (cmd_fire) begin
        if (cmd_on) begin
          if (hit) begin
            phase[hit_idx] <= '0;
            incr[hit_idx]  <= cmd_incr;
          end else if (free_any) begin
            active[free_idx] <= 1'b1;
            midi[free_idx]   <= cmd_midi;
            phase[free_idx]  <= '0;
            incr[free_idx]   <= cmd_incr;
          end else begin
            o_drop <= 1'b1;
          end
        end else if (hit) begin
          active[hit_idx] <= 1'b0;
        end
      end

      if (slot == SLOT_W'(NBANKS - 1))
        slot <= '0;
      else
        slot <= slot + 1'b1;
    end
  end

endmodule

// File: tb/tb_voice_bank_scheduler.sv
// Directed self-checking bench for voice_bank_scheduler.
module tb_voice_bank_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        panic;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_on;
  logic [6:0]  cmd_midi;
  logic [23:0] cmd_incr;
  logic [23:0] o_phase;
  logic [6:0]  o_midi;
  logic        o_valid;
  logic [3:0]  o_slot;
  logic [9:0]  o_active;
  logic        o_drop;

  int checks = 0;
  int errors = 0;

  voice_bank_scheduler #(.NBANKS(10), .SLOT_W(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .panic(panic),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_on(cmd_on),
    .cmd_midi(cmd_midi), .cmd_incr(cmd_incr),
    .o_phase(o_phase), .o_midi(o_midi), .o_valid(o_valid),
    .o_slot(o_slot), .o_active(o_active), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; clk_en = 1'b1; panic = 1'b0;
    cmd_valid = 1'b0; cmd_on = 1'b0; cmd_midi = '0; cmd_incr = '0;
    tick();
    rst = 1'b1;
  endtask

  task automatic send(input logic on, input logic [6:0] m, input logic [23:0] inc);
    cmd_valid = 1'b1; cmd_on = on; cmd_midi = m; cmd_incr = inc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_phase, o_midi, o_valid, o_slot, o_active, o_drop} !== '0) begin
      errors++; $display("FAIL reset_outputs got phase=%h midi=%0d valid=%b slot=%0d active=%h drop=%b want all 0",
                         o_phase, o_midi, o_valid, o_slot, o_active, o_drop);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (o_slot !== 4'(i % 10) || o_valid !== 1'b0 || o_phase !== 24'h0) begin
        errors++; $display("FAIL idle_rotation[%0d] got slot=%0d valid=%b phase=%h want slot=%0d valid=0 phase=0",
                           i, o_slot, o_valid, o_phase, i % 10);
      end
    end
  endtask

  task automatic test_note_on();
    do_reset();
    send(1'b1, 7'd69, 24'h001000);
    checks++;
    if (o_active !== 10'h001) begin
      errors++; $display("FAIL note_on_active got %h want 001", o_active);
    end
    for (int r = 0; r < 3; r++) begin
      repeat (10) tick();
      checks++;
      if (o_slot !== 4'd0 || o_valid !== 1'b1 || o_midi !== 7'd69 || o_phase !== 24'(r * 24'h001000)) begin
        errors++; $display("FAIL note_on_visit[%0d] got slot=%0d valid=%b midi=%0d phase=%h want slot=0 valid=1 midi=69 phase=%h",
                           r, o_slot, o_valid, o_midi, o_phase, r * 24'h001000);
      end
    end
  endtask

  task automatic test_fill_drop();
    bit found;
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b1, 7'(60 + i), 24'h000100);
    checks++;
    if (o_active !== 10'h3FF) begin
      errors++; $display("FAIL fill_active got %h want 3ff", o_active);
    end
    send(1'b1, 7'd70, 24'h000100);
    checks++;
    if (o_drop !== 1'b1 || o_active !== 10'h3FF) begin
      errors++; $display("FAIL drop_pulse got drop=%b active=%h want drop=1 active=3ff", o_drop, o_active);
    end
    tick();
    checks++;
    if (o_drop !== 1'b0) begin
      errors++; $display("FAIL drop_single_cycle got %b want 0", o_drop);
    end
    send(1'b0, 7'd63, 24'h0);
    checks++;
    if (o_active !== 10'h3F7 || o_drop !== 1'b0) begin
      errors++; $display("FAIL note_off_63 got active=%h drop=%b want 3f7 drop=0", o_active, o_drop);
    end
    send(1'b1, 7'd70, 24'h000100);
    checks++;
    if (o_active !== 10'h3FF || o_drop !== 1'b0) begin
      errors++; $display("FAIL realloc_active got active=%h drop=%b want 3ff drop=0", o_active, o_drop);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (o_slot === 4'd3) found = 1'b1;
    end
    checks++;
    if (!found || o_midi !== 7'd70 || o_valid !== 1'b1) begin
      errors++; $display("FAIL slot3_midi got found=%b midi=%0d valid=%b want found=1 midi=70 valid=1", found, o_midi, o_valid);
    end
  endtask

  task automatic test_wrap_retrigger();
    logic [23:0] exp [3];
    exp[0] = 24'h000000; exp[1] = 24'h800001; exp[2] = 24'h000002;
    do_reset();
    send(1'b1, 7'd50, 24'h800001);
    for (int r = 0; r < 3; r++) begin
      repeat (10) tick();
      checks++;
      if (o_slot !== 4'd0 || o_phase !== exp[r]) begin
        errors++; $display("FAIL wrap_phase[%0d] got slot=%0d phase=%h want slot=0 phase=%h", r, o_slot, o_phase, exp[r]);
      end
    end
    send(1'b1, 7'd50, 24'h800001);
    checks++;
    if (o_active !== 10'h001) begin
      errors++; $display("FAIL retrigger_no_alloc got active=%h want 001", o_active);
    end
    repeat (9) tick();
    checks++;
    if (o_slot !== 4'd0 || o_phase !== 24'h0 || o_valid !== 1'b1) begin
      errors++; $display("FAIL retrigger_phase got slot=%0d phase=%h valid=%b want slot=0 phase=0 valid=1", o_slot, o_phase, o_valid);
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    send(1'b1, 7'd69, 24'h000010);
    repeat (3) tick();
    checks++;
    if (o_slot !== 4'd3) begin
      errors++; $display("FAIL pre_freeze_slot got %0d want 3", o_slot);
    end
    clk_en = 1'b0;
    cmd_valid = 1'b1; cmd_on = 1'b1; cmd_midi = 7'd40; cmd_incr = 24'h1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL freeze_ready got %b want 0", cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_slot !== 4'd3 || o_active !== 10'h001 || o_valid !== 1'b0) begin
        errors++; $display("FAIL freeze_hold[%0d] got slot=%0d active=%h valid=%b want slot=3 active=001 valid=0",
                           i, o_slot, o_active, o_valid);
      end
    end
    cmd_valid = 1'b0;
    clk_en = 1'b1;
    tick();
    checks++;
    if (o_slot !== 4'd4) begin
      errors++; $display("FAIL resume_slot got %0d want 4", o_slot);
    end
  endtask

  task automatic test_panic_and_reset();
    do_reset();
    send(1'b1, 7'd60, 24'h000100);
    send(1'b1, 7'd61, 24'h000100);
    checks++;
    if (o_active !== 10'h003) begin
      errors++; $display("FAIL pre_panic_active got %h want 003", o_active);
    end
    panic = 1'b1;
    cmd_valid = 1'b1; cmd_on = 1'b1; cmd_midi = 7'd62; cmd_incr = 24'h100;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL panic_ready got %b want 0", cmd_ready);
    end
    tick();
    panic = 1'b0; cmd_valid = 1'b0;
    checks++;
    if (o_active !== 10'h000) begin
      errors++; $display("FAIL panic_active got %h want 000", o_active);
    end
    send(1'b1, 7'd64, 24'h000200);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", cmd_ready);
    end
    tick();
    checks++;
    if ({o_phase, o_midi, o_valid, o_slot, o_active, o_drop} !== '0) begin
      errors++; $display("FAIL midrun_reset got phase=%h midi=%0d valid=%b slot=%0d active=%h drop=%b want all 0",
                         o_phase, o_midi, o_valid, o_slot, o_active, o_drop);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (o_slot !== 4'd0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL restart_slot0 got slot=%0d valid=%b want 0 0", o_slot, o_valid);
    end
    tick();
    checks++;
    if (o_slot !== 4'd1) begin
      errors++; $display("FAIL restart_slot1 got %0d want 1", o_slot);
    end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; panic = 1'b0;
    cmd_valid = 1'b0; cmd_on = 1'b0; cmd_midi = '0; cmd_incr = '0;
    test_reset();
    test_note_on();
    test_fill_drop();
    test_wrap_retrigger();
    test_clk_en();
    test_panic_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
